// File: rtl/client_dir_write_buffer_if.sv
// Bundle of the write-buffer facing signals: pipeline write input, SRAM
// write port and the forwarding lookup used by the directory read path.
interface client_dir_write_buffer_if #(
  parameter int SET_BITS = 7,
  parameter int WAY_BITS = 4
);
  logic                       io_in_valid;
  logic [SET_BITS-1:0]        io_in_bits_set;
  logic [WAY_BITS-1:0]        io_in_bits_way;
  logic [1:0]                 io_in_bits_data_0_state;
  logic [1:0]                 io_in_bits_data_1_state;
  logic                       io_full;
  logic                       io_overflow;
  logic                       io_sram_w_valid;
  logic                       io_sram_w_ready;
  logic [SET_BITS-1:0]        io_sram_w_set;
  logic [(1<<WAY_BITS)-1:0]   io_sram_w_waymask;
  logic [3:0]                 io_sram_w_data;
  logic [SET_BITS-1:0]        io_lookup_set;
  logic [WAY_BITS-1:0]        io_lookup_way;
  logic                       io_lookup_hit;
  logic [1:0]                 io_lookup_data_0_state;
  logic [1:0]                 io_lookup_data_1_state;

  // Environment side: drives writes, SRAM ready and lookup queries.
  modport master (
    output io_in_valid, io_in_bits_set, io_in_bits_way,
           io_in_bits_data_0_state, io_in_bits_data_1_state,
           io_sram_w_ready, io_lookup_set, io_lookup_way,
    input  io_full, io_overflow, io_sram_w_valid, io_sram_w_set,
           io_sram_w_waymask, io_sram_w_data, io_lookup_hit,
           io_lookup_data_0_state, io_lookup_data_1_state
  );

  // Buffer side.
  modport slave (
    input  io_in_valid, io_in_bits_set, io_in_bits_way,
           io_in_bits_data_0_state, io_in_bits_data_1_state,
           io_sram_w_ready, io_lookup_set, io_lookup_way,
    output io_full, io_overflow, io_sram_w_valid, io_sram_w_set,
           io_sram_w_waymask, io_sram_w_data, io_lookup_hit,
           io_lookup_data_0_state, io_lookup_data_1_state
  );
endinterface

// File: rtl/client_dir_write_buffer.sv
// Coalescing write buffer between the client-directory write stage and the
// single-port client-state SRAM, with a forwarding lookup for pending writes.
module client_dir_write_buffer #(
  parameter int DEPTH    = 4,
  parameter int SET_BITS = 7,
  parameter int WAY_BITS = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  client_dir_write_buffer_if.slave    bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int MASK_W = 1 << WAY_BITS;

  logic [PTR_W-1:0]    head_q, tail_q;
  logic [CNT_W-1:0]    count_q;
  logic                overflow_q;

  logic [SET_BITS-1:0] ent_set [DEPTH];
  logic [WAY_BITS-1:0] ent_way [DEPTH];
  logic [1:0]          ent_d0  [DEPTH];
  logic [1:0]          ent_d1  [DEPTH];

  logic [DEPTH-1:0]    ent_valid, in_match, look_match;
  logic                match_any;
  logic [PTR_W-1:0]    match_idx;
  logic                not_full_or_fire, append, drop, fire, w_valid;

  assign w_valid          = (count_q != '0);
  assign fire             = w_valid & bus.io_sram_w_ready;
  assign not_full_or_fire = (count_q < CNT_W'(DEPTH)) | fire;
  assign append           = bus.io_in_valid & ~match_any & not_full_or_fire;
  assign drop             = bus.io_in_valid & ~match_any & ~not_full_or_fire;

  // Per-entry occupancy and compares; occupancy comes from the distance to head.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PTR_W-1:0] rel;
    logic             head_firing;
    assign rel            = PTR_W'(g) - head_q;
    assign ent_valid[g]   = ({1'b0, rel} < count_q);
    assign head_firing    = fire & (PTR_W'(g) == head_q);
    assign in_match[g]    = bus.io_in_valid & ent_valid[g] & ~head_firing &
                            (ent_set[g] == bus.io_in_bits_set) &
                            (ent_way[g] == bus.io_in_bits_way);
    assign look_match[g]  = ent_valid[g] &
                            (ent_set[g] == bus.io_lookup_set) &
                            (ent_way[g] == bus.io_lookup_way);
  end

  // Coalesce target and forwarded data; at most one entry per (set, way) so OR-merge is exact.
  always_comb begin
    match_any                  = 1'b0;
    match_idx                  = '0;
    bus.io_lookup_hit          = 1'b0;
    bus.io_lookup_data_0_state = '0;
    bus.io_lookup_data_1_state = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (in_match[i]) begin
        match_any = 1'b1;
        match_idx = PTR_W'(i);
      end
      if (look_match[i]) begin
        bus.io_lookup_hit          = 1'b1;
        bus.io_lookup_data_0_state = bus.io_lookup_data_0_state | ent_d0[i];
        bus.io_lookup_data_1_state = bus.io_lookup_data_1_state | ent_d1[i];
      end
    end
  end

  // SRAM payload straight from the head entry, forced to zero when the buffer is empty.
  always_comb begin
    bus.io_sram_w_valid   = w_valid;
    bus.io_sram_w_set     = '0;
    bus.io_sram_w_waymask = '0;
    bus.io_sram_w_data    = '0;
    if (w_valid) begin
      bus.io_sram_w_set     = ent_set[head_q];
      bus.io_sram_w_waymask = MASK_W'(1) << ent_way[head_q];
      bus.io_sram_w_data    = {ent_d1[head_q], ent_d0[head_q]};
    end
  end

  assign bus.io_full     = (count_q >= CNT_W'(DEPTH - 1));
  assign bus.io_overflow = overflow_q;

  // Queue control: pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (fire)   head_q <= head_q + 1'b1;
      if (append) tail_q <= tail_q + 1'b1;
      if (append && !fire)      count_q <= count_q + 1'b1;
      else if (fire && !append) count_q <= count_q - 1'b1;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Entry storage: append at tail or overwrite states of the coalesce target.
  always_ff @(posedge clock) begin
    if (append) begin
      ent_set[tail_q] <= bus.io_in_bits_set;
      ent_way[tail_q] <= bus.io_in_bits_way;
      ent_d0[tail_q]  <= bus.io_in_bits_data_0_state;
      ent_d1[tail_q]  <= bus.io_in_bits_data_1_state;
    end else if (match_any) begin
      ent_d0[match_idx] <= bus.io_in_bits_data_0_state;
      ent_d1[match_idx] <= bus.io_in_bits_data_1_state;
    end
  end
endmodule

// File: tb/tb_client_dir_write_buffer.sv
// Directed bench for the client-directory write buffer.
module tb_client_dir_write_buffer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  client_dir_write_buffer_if #(.SET_BITS(7), .WAY_BITS(4)) bus ();

  client_dir_write_buffer #(.DEPTH(4), .SET_BITS(7), .WAY_BITS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int s, input int w, input int d0, input int d1);
    bus.io_in_valid             = 1'b1;
    bus.io_in_bits_set          = 7'(s);
    bus.io_in_bits_way          = 4'(w);
    bus.io_in_bits_data_0_state = 2'(d0);
    bus.io_in_bits_data_1_state = 2'(d1);
  endtask

  task automatic idle();
    bus.io_in_valid = 1'b0;
  endtask

  task automatic look(input int s, input int w);
    bus.io_lookup_set = 7'(s);
    bus.io_lookup_way = 4'(w);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    bus.io_in_valid = 1'b0;
    bus.io_in_bits_set = '0;
    bus.io_in_bits_way = '0;
    bus.io_in_bits_data_0_state = '0;
    bus.io_in_bits_data_1_state = '0;
    bus.io_sram_w_ready = 1'b0;
    look(0, 0);
    #1;
    chk("rst_valid",    32'(bus.io_sram_w_valid), 0);
    chk("rst_full",     32'(bus.io_full), 0);
    chk("rst_overflow", 32'(bus.io_overflow), 0);
    chk("rst_hit",      32'(bus.io_lookup_hit), 0);
    chk("rst_mask",     32'(bus.io_sram_w_waymask), 0);
    do_reset();

    // Single write
    bus.io_sram_w_ready = 1'b1;
    wr(5, 3, 2, 1);
    tick();
    idle();
    look(5, 3);
    #1;
    chk("single_valid", 32'(bus.io_sram_w_valid), 1);
    chk("single_set",   32'(bus.io_sram_w_set), 5);
    chk("single_mask",  32'(bus.io_sram_w_waymask), 32'h0008);
    chk("single_data",  32'(bus.io_sram_w_data), 32'b0110);
    chk("single_hit",   32'(bus.io_lookup_hit), 1);
    chk("single_ld0",   32'(bus.io_lookup_data_0_state), 2);
    tick();
    chk("single_done",  32'(bus.io_sram_w_valid), 0);
    chk("single_miss",  32'(bus.io_lookup_hit), 0);
    chk("single_mdata", 32'(bus.io_lookup_data_0_state), 0);

    // Fill and overflow
    bus.io_sram_w_ready = 1'b0;
    wr(1, 0, 1, 0); tick();
    wr(2, 0, 1, 0); tick();
    chk("fill_full2", 32'(bus.io_full), 0);
    wr(3, 0, 1, 0); tick();
    chk("fill_full3", 32'(bus.io_full), 1);
    wr(4, 0, 1, 0); tick();
    chk("fill_ovf4", 32'(bus.io_overflow), 0);
    wr(5, 0, 1, 0); tick();
    idle();
    look(5, 0);
    #1;
    chk("fill_ovf5",  32'(bus.io_overflow), 1);
    chk("fill_drop",  32'(bus.io_lookup_hit), 0);
    bus.io_sram_w_ready = 1'b1;
    #1;
    chk("fill_set1", 32'(bus.io_sram_w_set), 1);
    tick();
    chk("fill_set2", 32'(bus.io_sram_w_set), 2);
    tick();
    chk("fill_set3", 32'(bus.io_sram_w_set), 3);
    chk("fill_nfull", 32'(bus.io_full), 0);
    tick();
    chk("fill_set4", 32'(bus.io_sram_w_set), 4);
    tick();
    chk("fill_empty", 32'(bus.io_sram_w_valid), 0);
    chk("fill_sticky", 32'(bus.io_overflow), 1);

    // Coalescing
    do_reset();
    chk("coal_ovf_clr", 32'(bus.io_overflow), 0);
    bus.io_sram_w_ready = 1'b0;
    wr(9, 2, 1, 1); tick();
    wr(9, 2, 3, 0); tick();
    idle();
    look(9, 2);
    #1;
    chk("coal_hit",  32'(bus.io_lookup_hit), 1);
    chk("coal_d0",   32'(bus.io_lookup_data_0_state), 3);
    chk("coal_d1",   32'(bus.io_lookup_data_1_state), 0);
    chk("coal_data", 32'(bus.io_sram_w_data), 32'b0011);
    bus.io_sram_w_ready = 1'b1;
    tick();
    chk("coal_single", 32'(bus.io_sram_w_valid), 0);

    // Enqueue at full while draining
    do_reset();
    bus.io_sram_w_ready = 1'b0;
    wr(1, 1, 0, 0); tick();
    wr(2, 1, 0, 0); tick();
    wr(3, 1, 0, 0); tick();
    wr(4, 1, 0, 0); tick();
    bus.io_sram_w_ready = 1'b1;
    wr(7, 5, 1, 2);
    #1;
    chk("fulld_head", 32'(bus.io_sram_w_set), 1);
    tick();
    idle();
    chk("fulld_ovf",  32'(bus.io_overflow), 0);
    chk("fulld_full", 32'(bus.io_full), 1);
    chk("fulld_s2",   32'(bus.io_sram_w_set), 2);
    tick();
    chk("fulld_s3",   32'(bus.io_sram_w_set), 3);
    tick();
    chk("fulld_s4",   32'(bus.io_sram_w_set), 4);
    tick();
    chk("fulld_s7",   32'(bus.io_sram_w_set), 7);
    chk("fulld_mask", 32'(bus.io_sram_w_waymask), 32'h0020);
    chk("fulld_data", 32'(bus.io_sram_w_data), 32'b1001);
    tick();
    chk("fulld_empty", 32'(bus.io_sram_w_valid), 0);

    // Write to the firing head
    do_reset();
    bus.io_sram_w_ready = 1'b0;
    wr(6, 1, 1, 1); tick();
    bus.io_sram_w_ready = 1'b1;
    wr(6, 1, 2, 0);
    #1;
    chk("hf_old_data", 32'(bus.io_sram_w_data), 32'b0101);
    tick();
    idle();
    bus.io_sram_w_ready = 1'b0;
    look(6, 1);
    #1;
    chk("hf_hit",   32'(bus.io_lookup_hit), 1);
    chk("hf_d0",    32'(bus.io_lookup_data_0_state), 2);
    chk("hf_valid", 32'(bus.io_sram_w_valid), 1);
    chk("hf_data",  32'(bus.io_sram_w_data), 32'b0010);
    bus.io_sram_w_ready = 1'b1;
    tick();
    chk("hf_empty", 32'(bus.io_sram_w_valid), 0);

    // Reset mid-operation
    do_reset();
    bus.io_sram_w_ready = 1'b0;
    wr(1, 2, 1, 1); tick();
    wr(2, 2, 1, 1); tick();
    wr(3, 2, 1, 1); tick();
    idle();
    look(2, 2);
    #1;
    chk("mr_full_pre", 32'(bus.io_full), 1);
    chk("mr_hit_pre",  32'(bus.io_lookup_hit), 1);
    #1;
    reset = 1'b0;
    #1;
    chk("mr_valid", 32'(bus.io_sram_w_valid), 0);
    chk("mr_full",  32'(bus.io_full), 0);
    chk("mr_hit",   32'(bus.io_lookup_hit), 0);
    @(negedge clock);
    reset = 1'b1;
    bus.io_sram_w_ready = 1'b1;
    tick();
    chk("mr_after1", 32'(bus.io_sram_w_valid), 0);
    tick();
    chk("mr_after2", 32'(bus.io_sram_w_valid), 0);
    chk("mr_full2",  32'(bus.io_full), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/client_dir_write_buffer.md
Name: client_dir_write_buffer

Overview:
- Consumer of the client-directory write pipeline stage. Takes its registered write request (set, way, two client states) every cycle it is valid; that stage has no ready, so this block never back-pressures it.
- Buffers writes in a small coalescing FIFO and drains them into the single-port client-state SRAM whenever the SRAM write port is free.
- Gives the directory read path a forwarding lookup so that pending writes are visible before they reach the SRAM.

Parameters:
- DEPTH, 4, buffer entries (power of two, ≥2)
- SET_BITS, 7, set index width
- WAY_BITS, 4, way index width; SRAM way mask is 2^WAY_BITS = 16 bits

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- io_in_valid  in  1  write request from pipeline stage
- io_in_bits_set  in  SET_BITS  target set
- io_in_bits_way  in  WAY_BITS  target way
- io_in_bits_data_0_state  in  2  client 0 state
- io_in_bits_data_1_state  in  2  client 1 state
- io_full  out  1  to directory control: suppress new writes
- io_overflow  out  1  sticky error: a write was dropped
- io_sram_w_valid  out  1  write request to SRAM
- io_sram_w_ready  in  1  SRAM accepts the write (low while an SRAM read is in progress)
- io_sram_w_set  out  SET_BITS  write set
- io_sram_w_waymask  out  16  one-hot way mask
- io_sram_w_data  out  4  {data_1_state, data_0_state}
- io_lookup_set  in  SET_BITS  forwarding query set
- io_lookup_way  in  WAY_BITS  forwarding query way
- io_lookup_hit  out  1  a buffered entry matches
- io_lookup_data_0_state  out  2  forwarded client 0 state; 0 on miss
- io_lookup_data_1_state  out  2  forwarded client 1 state; 0 on miss

Behaviour:
- Storage: circular FIFO with head/tail pointers and count 0..DEPTH. Each entry holds {set, way, d0, d1}.
- Reset (asynchronous, reset low):
  - count, head, tail and io_overflow clear to 0.
  - All outputs read 0.
  - Buffered writes are discarded, including when reset hits mid-drain.
- Drain:
  - io_sram_w_valid = (count != 0).
  - Payload comes straight from the head entry registers: waymask = 1 << way; data = {d1, d0}.
  - fire = valid & ready. On fire the head advances and the entry is freed at the clock edge.
  - The payload may change while valid is held and ready is low (head coalescing, see below); the SRAM samples only on fire.
- Enqueue, evaluated whenever io_in_valid:
  - Match: a valid entry with equal set and way, excluding the head when fire is high this cycle.
  - If there is a match, overwrite that entry's d0/d1 in place. Count is unchanged.
  - If there is no match and (count < DEPTH or fire), write a new entry at the tail and advance the tail.
  - Otherwise drop the request and set io_overflow = 1. It stays set until reset.
- Count update: +1 on append only, −1 on fire only, unchanged when both or neither occur.
- Latency: a write presented in cycle N is visible on io_sram_w_valid/payload and on lookup from cycle N+1. Lookup does not see the in-flight io_in write in the same cycle.
- Invariant: at most one valid entry per (set, way). Lookup therefore needs no priority logic. It is a combinational compare over valid entries, and includes the head even while the head fires.
- io_full = (count >= DEPTH-1), combinational from the count register. The one-entry margin covers the upstream stage already holding a write.
- Ordering: entries drain strictly in FIFO order. A coalesced entry keeps its original position in the queue.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by count, not by pointer equality.

Test Plan:
- Single write:
  - Stimulus: ready=1; write set=5, way=3, d0=2, d1=1 in cycle 0.
  - Response: cycle 1 shows valid=1, set=5, waymask=0x0008, data=4'b0110; fire; cycle 2 valid=0, count=0.
- Fill and overflow:
  - Stimulus: ready=0; distinct writes to (1,0), (2,0), (3,0), (4,0), then (5,0).
  - Response:
    - io_full goes high the cycle after the 3rd write.
    - The 5th write is dropped and io_overflow=1.
    - After raising ready, the SRAM sees sets 1, 2, 3, 4 in order on four consecutive cycles.
- Coalescing:
  - Stimulus: ready=0; write (9,2,d0=1,d1=1), then (9,2,d0=3,d1=0).
  - Response: count=1; lookup (9,2) gives hit=1, d0=3, d1=0; on drain, data=4'b0011 with a single fire.
- Enqueue at full while draining:
  - Stimulus: count=4, ready=1, new write to (7,5) in the same cycle.
  - Response: accepted, count stays 4, io_overflow=0, and (7,5) drains last.
- Write to the firing head:
  - Stimulus: head is (6,1), ready=1; write (6,1,d0=2) in the same cycle.
  - Response: the old head data goes to the SRAM; a new tail entry (6,1,d0=2) is appended; lookup (6,1) in the next cycle gives hit with d0=2.
- Reset mid-operation:
  - Stimulus: 3 entries pending; assert reset asynchronously, mid-cycle.
  - Response: io_sram_w_valid, io_full and io_lookup_hit drop immediately; after release no SRAM write occurs and count=0.
